// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID->EX pipeline register with an operand-forwarding unit in front of the ALU.
// An entry offered by decode is captured with a valid/ready handshake. While an
// entry is held, both source operands are resolved against the EX/MEM and
// MEM/WB result buses. This happens combinationally on the outputs, and the
// held operands are also rewritten every stalled cycle. That way a producer
// that retires while execute is stalled is not lost.
//
// Parameters
//   XLEN        datapath width
//   REG_ADDR_W  register-address width
//   OP_W        ALU opcode width
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               kill the held entry and drop the offered instruction
//   id_valid/id_ready   decode-side handshake
//   id_*                decoded instruction fields and regfile read data
//   exm_*, wb_*         EX/MEM and MEM/WB writeback buses used for forwarding
//   ex_valid/ex_ready   execute-side handshake
//   Reg1, Reg2, AluOP   ALU operands and opcode
//   ex_rs2_data         forwarded rs2 used as store data (never the immediate)
//   ex_rd_addr, ex_reg_write, ex_pc   held destination, write enable, PC
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OP_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,

  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic                  id_use_imm,
  input  logic [OP_W-1:0]       id_alu_op,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_reg_write,

  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  exm_reg_write,
  input  logic [XLEN-1:0]       exm_result,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic [XLEN-1:0]       wb_result,

  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [XLEN-1:0]       Reg1,
  output logic [XLEN-1:0]       Reg2,
  output logic [OP_W-1:0]       AluOP,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic [XLEN-1:0]       ex_pc
);

  // ---------------------------------------------------------------------------
  // Forwarding mux. The EX/MEM bus holds the younger producer, so it wins over
  // MEM/WB. x0 is never forwarded because the regfile always reads it as zero.
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] fwd(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [XLEN-1:0]       data
  );
    logic [XLEN-1:0] res;
    res = data;
    if (addr != '0) begin
      if (exm_reg_write && (exm_rd == addr))
        res = exm_result;
      else if (wb_reg_write && (wb_rd == addr))
        res = wb_result;
    end
    return res;
  endfunction

  // Held entry
  logic [XLEN-1:0]       pc_q;
  logic [REG_ADDR_W-1:0] rs1_q;
  logic [REG_ADDR_W-1:0] rs2_q;
  logic [XLEN-1:0]       op1_q;
  logic [XLEN-1:0]       op2_q;
  logic [XLEN-1:0]       imm_q;
  logic                  use_imm_q;
  logic [OP_W-1:0]       alu_op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  reg_write_q;
  logic                  valid_q;

  // Handshake decode
  logic do_load;
  logic do_hold;
  logic do_drain;

  // The stage is free when empty or when execute takes the entry this cycle.
  // This does not depend on id_valid, so no combinational loop forms upstream.
  assign id_ready = !valid_q || ex_ready;

  assign do_load  = id_valid && id_ready && !flush;
  assign do_hold  = valid_q && !ex_ready && !flush;
  assign do_drain = valid_q && ex_ready && !id_valid && !flush;

  // Forwarded operands from held state. They are used both for the outputs
  // and for the stall-time refresh.
  logic [XLEN-1:0] op1_fwd;
  logic [XLEN-1:0] op2_fwd;

  assign op1_fwd = fwd(rs1_q, op1_q);
  assign op2_fwd = fwd(rs2_q, op2_q);

  // ---------------------------------------------------------------------------
  // State update. Flush has priority over everything: the held entry is
  // invalidated and the instruction offered this cycle is discarded.
  // ---------------------------------------------------------------------------
  // NOTE: every register here uses non-blocking assignment so all of them
  // sample pre-edge values. A blocking assignment would let op1_q's refresh
  // see a half-updated entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset as well as valid. The outputs are
      // then defined zeros out of reset instead of X. The specification
      // requires this, and it is cheap for flops (unlike a RAM).
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      alu_op_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (do_load) begin
      valid_q     <= 1'b1;
      pc_q        <= id_pc;
      rs1_q       <= id_rs1_addr;
      rs2_q       <= id_rs2_addr;
      op1_q       <= fwd(id_rs1_addr, id_rs1_data);
      op2_q       <= fwd(id_rs2_addr, id_rs2_data);
      imm_q       <= id_imm;
      use_imm_q   <= id_use_imm;
      alu_op_q    <= id_alu_op;
      rd_q        <= id_rd_addr;
      reg_write_q <= id_reg_write;
    end else if (do_hold) begin
      // Capture any producer visible this cycle. The value it supplies then
      // survives after that producer leaves the writeback buses.
      op1_q <= op1_fwd;
      op2_q <= op2_fwd;
    end else if (do_drain) begin
      valid_q <= 1'b0;
    end
  end

  // Outputs
  assign ex_valid     = valid_q;
  assign Reg1         = op1_fwd;
  assign ex_rs2_data  = op2_fwd;
  assign Reg2         = use_imm_q ? imm_q : op2_fwd;
  assign AluOP        = alu_op_q;
  assign ex_rd_addr   = rd_q;
  assign ex_reg_write = reg_write_q && valid_q;
  assign ex_pc        = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed, table-driven bench for id_ex_stage. Each table row drives one
// cycle of inputs and states the expected id_ready before the edge and the
// expected outputs after the edge. Hand-written sequences cover reset during
// operation and back-to-back throughput.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int OPW  = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [RAW-1:0]  id_rs1_addr, id_rs2_addr;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic            id_use_imm;
  logic [OPW-1:0]  id_alu_op;
  logic [RAW-1:0]  id_rd_addr;
  logic            id_reg_write;
  logic [RAW-1:0]  exm_rd, wb_rd;
  logic            exm_reg_write, wb_reg_write;
  logic [XLEN-1:0] exm_result, wb_result;
  logic            ex_valid, ex_ready;
  logic [XLEN-1:0] Reg1, Reg2, ex_rs2_data, ex_pc;
  logic [OPW-1:0]  AluOP;
  logic [RAW-1:0]  ex_rd_addr;
  logic            ex_reg_write;

  id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW), .OP_W(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .Reg1(Reg1), .Reg2(Reg2), .AluOP(AluOP), .ex_rs2_data(ex_rs2_data),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_pc(ex_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            flush, id_valid, ex_ready;
    logic [XLEN-1:0] pc;
    logic [RAW-1:0]  rs1, rs2;
    logic [XLEN-1:0] d1, d2, imm;
    logic            use_imm;
    logic [OPW-1:0]  op;
    logic [RAW-1:0]  rd;
    logic            rw;
    logic [RAW-1:0]  exm_rd;
    logic            exm_rw;
    logic [XLEN-1:0] exm_res;
    logic [RAW-1:0]  wb_rd;
    logic            wb_rw;
    logic [XLEN-1:0] wb_res;
    // expectations
    logic            e_ready;   // id_ready before the edge
    logic            e_valid;
    logic            e_rw;      // ex_reg_write
    logic            chk_data;  // compare held data fields
    logic [XLEN-1:0] e_reg1, e_reg2, e_rs2, e_pc;
    logic [OPW-1:0]  e_op;
    logic [RAW-1:0]  e_rd;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  function automatic vec_t blank();
    vec_t v;
    v.flush = 0; v.id_valid = 0; v.ex_ready = 0; v.pc = 0;
    v.rs1 = 0; v.rs2 = 0; v.d1 = 0; v.d2 = 0; v.imm = 0; v.use_imm = 0;
    v.op = 0; v.rd = 0; v.rw = 0;
    v.exm_rd = 0; v.exm_rw = 0; v.exm_res = 0;
    v.wb_rd = 0; v.wb_rw = 0; v.wb_res = 0;
    v.e_ready = 0; v.e_valid = 0; v.e_rw = 0; v.chk_data = 0;
    v.e_reg1 = 0; v.e_reg2 = 0; v.e_rs2 = 0; v.e_pc = 0; v.e_op = 0; v.e_rd = 0;
    return v;
  endfunction

  task automatic drive_idle();
    flush = 0; id_valid = 0; ex_ready = 0; id_pc = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_use_imm = 0; id_alu_op = 0; id_rd_addr = 0; id_reg_write = 0;
    exm_rd = 0; exm_reg_write = 0; exm_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    flush = v.flush; id_valid = v.id_valid; ex_ready = v.ex_ready; id_pc = v.pc;
    id_rs1_addr = v.rs1; id_rs2_addr = v.rs2; id_rs1_data = v.d1; id_rs2_data = v.d2;
    id_imm = v.imm; id_use_imm = v.use_imm; id_alu_op = v.op;
    id_rd_addr = v.rd; id_reg_write = v.rw;
    exm_rd = v.exm_rd; exm_reg_write = v.exm_rw; exm_result = v.exm_res;
    wb_rd = v.wb_rd; wb_reg_write = v.wb_rw; wb_result = v.wb_res;
  endtask

  initial begin
    vec_t v;

    // 0: plain load, no bypass
    v = blank(); v.id_valid = 1; v.ex_ready = 1; v.pc = 32'h100;
    v.rs1 = 5; v.d1 = 32'h10; v.rs2 = 6; v.d2 = 32'h20; v.op = 2; v.rd = 3; v.rw = 1;
    v.e_ready = 1; v.e_valid = 1; v.e_rw = 1; v.chk_data = 1;
    v.e_reg1 = 32'h10; v.e_reg2 = 32'h20; v.e_rs2 = 32'h20; v.e_op = 2; v.e_rd = 3; v.e_pc = 32'h100;
    vecs[0] = v;
    // 1: stall, nothing changes
    v.id_valid = 0; v.ex_ready = 0; v.e_ready = 0;
    vecs[1] = v;
    // 2: EX/MEM beats MEM/WB on rs1
    v = blank(); v.id_valid = 1; v.ex_ready = 1; v.pc = 32'h104;
    v.rs1 = 7; v.d1 = 32'h1; v.rs2 = 8; v.d2 = 32'h2; v.op = 4; v.rd = 9; v.rw = 1;
    v.exm_rd = 7; v.exm_rw = 1; v.exm_res = 32'hAAAA; v.wb_rd = 7; v.wb_rw = 1; v.wb_res = 32'hBBBB;
    v.e_ready = 1; v.e_valid = 1; v.e_rw = 1; v.chk_data = 1;
    v.e_reg1 = 32'hAAAA; v.e_reg2 = 32'h2; v.e_rs2 = 32'h2; v.e_op = 4; v.e_rd = 9; v.e_pc = 32'h104;
    vecs[2] = v;
    // 3: x0 never forwarded
    v = blank(); v.id_valid = 1; v.ex_ready = 1; v.pc = 32'h108;
    v.rs1 = 0; v.d1 = 32'h33; v.rs2 = 0; v.d2 = 32'h44; v.op = 1;
    v.exm_rd = 0; v.exm_rw = 1; v.exm_res = 32'hDEAD; v.wb_rd = 0; v.wb_rw = 1; v.wb_res = 32'hBEEF;
    v.e_ready = 1; v.e_valid = 1; v.e_rw = 0; v.chk_data = 1;
    v.e_reg1 = 32'h33; v.e_reg2 = 32'h44; v.e_rs2 = 32'h44; v.e_op = 1; v.e_rd = 0; v.e_pc = 32'h108;
    vecs[3] = v;
    // 4: MEM/WB forward on rs2, EX/MEM not writing
    v = blank(); v.id_valid = 1; v.ex_ready = 1; v.pc = 32'h10C;
    v.rs1 = 10; v.d1 = 32'h1; v.rs2 = 11; v.d2 = 32'h2; v.op = 3; v.rd = 12; v.rw = 1;
    v.exm_rd = 10; v.exm_rw = 0; v.exm_res = 32'h99; v.wb_rd = 11; v.wb_rw = 1; v.wb_res = 32'h77;
    v.e_ready = 1; v.e_valid = 1; v.e_rw = 1; v.chk_data = 1;
    v.e_reg1 = 32'h1; v.e_reg2 = 32'h77; v.e_rs2 = 32'h77; v.e_op = 3; v.e_rd = 12; v.e_pc = 32'h10C;
    vecs[4] = v;
    // 5: immediate operand
    v = blank(); v.id_valid = 1; v.ex_ready = 1; v.pc = 32'h110;
    v.rs1 = 1; v.d1 = 32'h5; v.rs2 = 2; v.d2 = 32'h6; v.imm = 32'hFFFF_FFF0; v.use_imm = 1;
    v.op = 6; v.rd = 4; v.rw = 1;
    v.e_ready = 1; v.e_valid = 1; v.e_rw = 1; v.chk_data = 1;
    v.e_reg1 = 32'h5; v.e_reg2 = 32'hFFFF_FFF0; v.e_rs2 = 32'h6; v.e_op = 6; v.e_rd = 4; v.e_pc = 32'h110;
    vecs[5] = v;
    // 6: stall with WB producing rs2; new offer must not be taken
    v.id_valid = 1; v.ex_ready = 0; v.pc = 32'h200; v.d1 = 32'hEE; v.op = 9;
    v.wb_rd = 2; v.wb_rw = 1; v.wb_res = 32'h55;
    v.e_ready = 0; v.e_rs2 = 32'h55;
    vecs[6] = v;
    // 7: producer gone, refreshed value retained
    v.id_valid = 0; v.wb_rd = 0; v.wb_rw = 0; v.wb_res = 0;
    vecs[7] = v;
    // 8: drain
    v = blank(); v.ex_ready = 1; v.e_ready = 1;
    vecs[8] = v;
    // 9: load into empty stage with ex_ready low
    v = blank(); v.id_valid = 1; v.ex_ready = 0; v.pc = 32'h300;
    v.rs1 = 3; v.d1 = 32'h123; v.rs2 = 4; v.d2 = 32'h456; v.op = 7; v.rd = 5; v.rw = 1;
    v.e_ready = 1; v.e_valid = 1; v.e_rw = 1; v.chk_data = 1;
    v.e_reg1 = 32'h123; v.e_reg2 = 32'h456; v.e_rs2 = 32'h456; v.e_op = 7; v.e_rd = 5; v.e_pc = 32'h300;
    vecs[9] = v;
    // 10: flush with valid entry and offered instruction
    v = blank(); v.flush = 1; v.id_valid = 1; v.ex_ready = 1; v.pc = 32'h400; v.rd = 6; v.rw = 1;
    v.e_ready = 1;
    vecs[10] = v;
    // 11: flush with empty stage and offered instruction
    v.ex_ready = 0; v.pc = 32'h500;
    vecs[11] = v;
    // 12: recovery load, both sources from EX/MEM, no write-back
    v = blank(); v.id_valid = 1; v.ex_ready = 0; v.pc = 32'h600;
    v.rs1 = 9; v.d1 = 32'h9; v.rs2 = 9; v.d2 = 32'h9; v.op = 5; v.rd = 9; v.rw = 0;
    v.exm_rd = 9; v.exm_rw = 1; v.exm_res = 32'h1234;
    v.e_ready = 1; v.e_valid = 1; v.e_rw = 0; v.chk_data = 1;
    v.e_reg1 = 32'h1234; v.e_reg2 = 32'h1234; v.e_rs2 = 32'h1234; v.e_op = 5; v.e_rd = 9; v.e_pc = 32'h600;
    vecs[12] = v;

    // ---- reset state ----
    drive_idle();
    rst_n = 1'b0;
    #12;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_reg1", Reg1, 32'd0);
    check("rst_reg2", Reg2, 32'd0);
    check("rst_aluop", 32'(AluOP), 32'd0);
    check("rst_rd", 32'(ex_rd_addr), 32'd0);
    check("rst_reg_write", 32'(ex_reg_write), 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    check("rst_id_ready", 32'(id_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive_vec(vecs[i]);
      #1;
      check($sformatf("v%0d_id_ready", i), 32'(id_ready), 32'(vecs[i].e_ready));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_ex_reg_write", i), 32'(ex_reg_write), 32'(vecs[i].e_rw));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_reg1", i), Reg1, vecs[i].e_reg1);
        check($sformatf("v%0d_reg2", i), Reg2, vecs[i].e_reg2);
        check($sformatf("v%0d_rs2_data", i), ex_rs2_data, vecs[i].e_rs2);
        check($sformatf("v%0d_aluop", i), 32'(AluOP), 32'(vecs[i].e_op));
        check($sformatf("v%0d_rd", i), 32'(ex_rd_addr), 32'(vecs[i].e_rd));
        check($sformatf("v%0d_pc", i), ex_pc, vecs[i].e_pc);
      end
    end

    // ---- reset mid-operation: entry 0x600 is held, op 5 ----
    @(negedge clk);
    drive_idle();
    #1;
    check("mid_pre_valid", 32'(ex_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ex_valid), 32'd0);
    check("mid_rst_reg1", Reg1, 32'd0);
    check("mid_rst_aluop", 32'(AluOP), 32'd0);
    check("mid_rst_id_ready", 32'(id_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- back-to-back throughput ----
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      id_valid = 1; ex_ready = 1; id_pc = 32'(i * 4);
      id_rs1_addr = 5'd1; id_rs1_data = 32'(i + 100);
      @(posedge clk);
      #1;
      check($sformatf("tp%0d_valid", i), 32'(ex_valid), 32'd1);
      check($sformatf("tp%0d_pc", i), ex_pc, 32'(i * 4));
      check($sformatf("tp%0d_reg1", i), Reg1, 32'(i + 100));
    end
    @(negedge clk);
    id_valid = 0;
    @(posedge clk);
    #1;
    check("tp_drain_valid", 32'(ex_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
